// File: rtl/lsu_axil_if.sv
// AXI-Lite master/slave bundle used by the load/store unit: 32-bit data,
// parameterised address width.
interface lsu_axil_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_axil.sv
// Single-outstanding load/store unit: turns one CPU byte/half/word access into
// an AXI-Lite read or write, with alignment checking and load extension.
module lsu_axil #(
    parameter  int XLEN         = 32,
    parameter  int ADDR_WIDTH   = 16,
    localparam int LS_SEL_WIDTH = 3
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_N,
    input  logic                  i_Req_Valid,
    output logic                  o_Req_Ready,
    input  logic [LS_SEL_WIDTH:0] i_Load_Store_Type,
    input  logic [XLEN-1:0]       i_Addr,
    input  logic [XLEN-1:0]       i_Data,
    output logic [XLEN-1:0]       o_Data,
    output logic                  o_Done,
    output logic                  o_Misaligned,
    output logic                  o_Error,
    lsu_axil_if.master            m_axil
);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LB  = (LS_SEL_WIDTH+1)'(1);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LH  = (LS_SEL_WIDTH+1)'(2);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LW  = (LS_SEL_WIDTH+1)'(3);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LBU = (LS_SEL_WIDTH+1)'(4);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LHU = (LS_SEL_WIDTH+1)'(5);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SB  = (LS_SEL_WIDTH+1)'(6);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SH  = (LS_SEL_WIDTH+1)'(7);
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SW  = (LS_SEL_WIDTH+1)'(8);

    typedef enum logic [2:0] {
        IDLE, READ_ADDR, READ_DATA, WRITE_REQ, WRITE_RESP, DONE
    } state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t                state_q, state_d;
    size_t                 req_size, size_q;
    logic                  req_load, req_store, req_sext, req_misaligned;
    logic                  sext_q, mis_q, err_q, aw_done, w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       data_q, load_ext;
    logic [31:0]           rdata_shifted;
    logic                  aw_hs, w_hs;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^i_Addr[XLEN-1:ADDR_WIDTH];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        req_load  = 1'b0;
        req_store = 1'b0;
        req_sext  = 1'b0;
        req_size  = SZ_WORD;
        case (i_Load_Store_Type)
            LS_TYPE_LB:  begin req_load  = 1'b1; req_sext = 1'b1; req_size = SZ_BYTE; end
            LS_TYPE_LH:  begin req_load  = 1'b1; req_sext = 1'b1; req_size = SZ_HALF; end
            LS_TYPE_LW:  begin req_load  = 1'b1; end
            LS_TYPE_LBU: begin req_load  = 1'b1; req_size = SZ_BYTE; end
            LS_TYPE_LHU: begin req_load  = 1'b1; req_size = SZ_HALF; end
            LS_TYPE_SB:  begin req_store = 1'b1; req_size = SZ_BYTE; end
            LS_TYPE_SH:  begin req_store = 1'b1; req_size = SZ_HALF; end
            LS_TYPE_SW:  begin req_store = 1'b1; end
            default:     ;
        endcase
        req_misaligned = (req_load || req_store) &&
                         ((req_size == SZ_HALF && i_Addr[0]) ||
                          (req_size == SZ_WORD && i_Addr[1:0] != 2'b00));
    end

    // Valid/ready outputs depend only on state and completion flags.
    assign o_Req_Ready    = (state_q == IDLE);
    assign o_Done         = (state_q == DONE);
    assign o_Misaligned   = o_Done && mis_q;
    assign o_Error        = o_Done && err_q;
    assign m_axil.arvalid = (state_q == READ_ADDR);
    assign m_axil.rready  = (state_q == READ_DATA);
    assign m_axil.awvalid = (state_q == WRITE_REQ) && !aw_done;
    assign m_axil.wvalid  = (state_q == WRITE_REQ) && !w_done;
    assign m_axil.bready  = (state_q == WRITE_RESP);
    assign m_axil.araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign m_axil.awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    assign aw_hs = m_axil.awvalid && m_axil.awready;
    assign w_hs  = m_axil.wvalid && m_axil.wready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_Req_Valid) begin
                if (req_misaligned || !(req_load || req_store)) state_d = DONE;
                else if (req_load)                                state_d = READ_ADDR;
                else                                              state_d = WRITE_REQ;
            end
            READ_ADDR:  if (m_axil.arready) state_d = READ_DATA;
            READ_DATA:  if (m_axil.rvalid)  state_d = DONE;
            WRITE_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WRITE_RESP;
            WRITE_RESP: if (m_axil.bvalid)  state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_shifted = m_axil.rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = {{(XLEN-8){sext_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_HALF: load_ext = {{(XLEN-16){sext_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = XLEN'(rdata_shifted);
        endcase

        m_axil.wstrb = 4'b1111;
        m_axil.wdata = data_q[31:0];
        case (size_q)
            SZ_BYTE: begin
                m_axil.wstrb = 4'b0001 << addr_q[1:0];
                m_axil.wdata = {4{data_q[7:0]}};
            end
            SZ_HALF: begin
                m_axil.wstrb = 4'b0011 << addr_q[1:0];
                m_axil.wdata = {2{data_q[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            state_q <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            o_Data  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (i_Req_Valid) begin
                    mis_q <= req_misaligned;
                    err_q <= 1'b0;
                end
                READ_DATA: if (m_axil.rvalid) begin
                    err_q  <= |m_axil.rresp;
                    o_Data <= load_ext;
                end
                WRITE_REQ: if (state_d == WRITE_RESP) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WRITE_RESP: if (m_axil.bvalid) err_q <= |m_axil.bresp;
                default: ;
            endcase
        end
    end

    // NOTE: request payload is pure datapath, only read after a capture, so it carries no reset.
    always_ff @(posedge i_Clock) begin
        if (o_Req_Ready && i_Req_Valid) begin
            addr_q <= i_Addr[ADDR_WIDTH-1:0];
            data_q <= i_Data;
            size_q <= req_size;
            sext_q <= req_sext;
        end
    end
endmodule

// File: tb/tb_lsu_axil.sv
// Directed bench for lsu_axil: a cycle-level AXI-Lite slave with per-channel
// delays, and a scoreboard of expected completions checked on every o_Done.
module tb_lsu_axil;
    localparam int XLEN = 32;
    localparam int AW   = 16;

    localparam logic [3:0] T_LB = 4'd1, T_LH = 4'd2, T_LW = 4'd3, T_LBU = 4'd4,
                           T_LHU = 4'd5, T_SB = 4'd6, T_SH = 4'd7, T_SW = 4'd8,
                           T_BAD = 4'd15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      ls_type;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data_in;
    logic [XLEN-1:0] data_out;
    logic            done;
    logic            mis;
    logic            err;

    lsu_axil_if #(.ADDR_WIDTH(AW)) axil();

    lsu_axil #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
        .i_Clock          (clk),
        .i_Reset_N        (rst_n),
        .i_Req_Valid      (req_valid),
        .o_Req_Ready      (req_ready),
        .i_Load_Store_Type(ls_type),
        .i_Addr           (addr),
        .i_Data           (data_in),
        .o_Data           (data_out),
        .o_Done           (done),
        .o_Misaligned     (mis),
        .o_Error          (err),
        .m_axil           (axil)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
        logic        err;
        int          done_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   ar_cycles = 0;
    int   aw_cycles = 0;

    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] rd_val = '0;
    logic [1:0]  rresp_val = '0, bresp_val = '0;
    logic [AW-1:0] cap_araddr = '0, cap_awaddr = '0;
    logic [31:0]   cap_wdata = '0;
    logic [3:0]    cap_wstrb = '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Cycle-level slave: all slave outputs change on the falling edge.
    initial begin
        int  ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        bit  ar_got = 0, aw_got = 0, w_got = 0, r_armed = 0, b_armed = 0;
        exp_t e;
        axil.arready = 0; axil.rvalid = 0; axil.rdata = '0; axil.rresp = '0;
        axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.bresp = '0;
        forever begin
            @(negedge clk);
            if (axil.arvalid) ar_cycles++;
            if (axil.awvalid) aw_cycles++;

            if (axil.arready) axil.arready = 0;
            else if (axil.arvalid) begin
                if (ar_cnt >= ar_delay) begin
                    axil.arready = 1; cap_araddr = axil.araddr; ar_got = 1; ar_cnt = 0;
                end else ar_cnt++;
            end else ar_cnt = 0;

            if (r_armed) begin
                axil.rvalid = 0; r_armed = 0; ar_got = 0;
            end else if (axil.rvalid) begin
                if (axil.rready) r_armed = 1;
            end else if (ar_got && !axil.arready) begin
                if (r_cnt >= r_delay) begin
                    axil.rvalid = 1; axil.rdata = rd_val; axil.rresp = rresp_val; r_cnt = 0;
                    if (axil.rready) r_armed = 1;
                end else r_cnt++;
            end

            if (axil.awready) axil.awready = 0;
            else if (axil.awvalid) begin
                if (aw_cnt >= aw_delay) begin
                    axil.awready = 1; cap_awaddr = axil.awaddr; aw_got = 1; aw_cnt = 0;
                end else aw_cnt++;
            end else aw_cnt = 0;

            if (axil.wready) axil.wready = 0;
            else if (axil.wvalid) begin
                if (w_cnt >= w_delay) begin
                    axil.wready = 1; cap_wdata = axil.wdata; cap_wstrb = axil.wstrb; w_got = 1; w_cnt = 0;
                end else w_cnt++;
            end else w_cnt = 0;

            if (b_armed) begin
                axil.bvalid = 0; b_armed = 0; aw_got = 0; w_got = 0;
            end else if (axil.bvalid) begin
                if (axil.bready) b_armed = 1;
            end else if (aw_got && w_got && !axil.awready && !axil.wready) begin
                if (b_cnt >= b_delay) begin
                    axil.bvalid = 1; axil.bresp = bresp_val; b_cnt = 0;
                    if (axil.bready) b_armed = 1;
                end else b_cnt++;
            end

            if (done) begin
                done_cnt++;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check({e.tag, "_data"}, data_out, e.data);
                    check({e.tag, "_mis"}, 32'(mis), 32'(e.mis));
                    check({e.tag, "_err"}, 32'(err), 32'(e.err));
                    check({e.tag, "_done_edge"}, 32'(cyc + 1), 32'(e.done_edge));
                end
            end
        end
    end

    // Drives one request for a single cycle; lat is the accept-to-o_Done edge distance.
    task automatic issue(input string tag, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] d, input bit expect_done, input logic [31:0] exp_data,
                         input logic exp_mis, input logic exp_err, input int lat);
        int n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        ls_type = t; addr = a; data_in = d; req_valid = 1;
        if (expect_done) sb.push_back('{tag, exp_data, exp_mis, exp_err, cyc + 1 + lat});
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_cnt < target && n < 60) begin @(negedge clk); n++; end
        check({tag, "_completed"}, 32'(done_cnt >= target), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int ar_before, aw_before;
        rst_n = 0; req_valid = 0; ls_type = '0; addr = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {axil.arvalid, axil.awvalid, axil.wvalid, axil.rready,
                                axil.bready, done, mis, err}, 32'd0);
        check("reset_data", data_out, 32'd0);
        rst_n = 1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // LB at 0x3, byte 0x80 sign-extends
        rd_val = 32'h80FF_FF00;
        issue("lb", T_LB, 32'h3, 32'h0, 1, 32'hFFFF_FF80, 0, 0, 3);
        wait_done("lb", 1);
        check("lb_araddr", 32'(cap_araddr), 32'h0000);

        // SH with W accepted three cycles before AW
        aw_delay = 3;
        issue("sh", T_SH, 32'h102, 32'h0000_1234, 1, 32'hFFFF_FF80, 0, 0, 6);
        wait_done("sh", 2);
        repeat (3) @(negedge clk);
        check("sh_single_done", 32'(done_cnt), 32'd2);
        check("sh_awaddr", 32'(cap_awaddr), 32'h0100);
        check("sh_wdata", cap_wdata, 32'h1234_1234);
        check("sh_wstrb", 32'(cap_wstrb), 32'hC);
        aw_delay = 0;

        // Misaligned LW: no bus traffic, data held
        ar_before = ar_cycles;
        issue("lw_mis", T_LW, 32'h6, 32'h0, 1, 32'hFFFF_FF80, 1, 0, 1);
        wait_done("lw_mis", 3);
        check("lw_mis_no_ar", 32'(ar_cycles), 32'(ar_before));

        // LHU with slow R and SLVERR; a request while busy must be ignored
        rd_val = 32'hBEEF_0000; r_delay = 5; rresp_val = 2'b10;
        aw_before = aw_cycles;
        issue("lhu", T_LHU, 32'h2, 32'h0, 1, 32'h0000_BEEF, 0, 1, 8);
        ls_type = T_SW; addr = 32'h40; req_valid = 1;
        repeat (3) begin
            check("busy_not_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 0;
        wait_done("lhu", 4);
        check("busy_req_ignored", 32'(aw_cycles), 32'(aw_before));
        r_delay = 0; rresp_val = 2'b00;

        rd_val = 32'h8001_1234;
        issue("lh", T_LH, 32'h2, 32'h0, 1, 32'hFFFF_8001, 0, 0, 3);
        wait_done("lh", 5);

        rd_val = 32'h0000_F000;
        issue("lbu", T_LBU, 32'h1, 32'h0, 1, 32'h0000_00F0, 0, 0, 3);
        wait_done("lbu", 6);

        rd_val = 32'hDEAD_BEEF; ar_delay = 2;
        issue("lw", T_LW, 32'h4, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, 5);
        wait_done("lw", 7);
        check("lw_araddr", 32'(cap_araddr), 32'h0004);
        ar_delay = 0;

        bresp_val = 2'b01;
        issue("sb", T_SB, 32'h1, 32'h0000_00A5, 1, 32'hDEAD_BEEF, 0, 1, 3);
        wait_done("sb", 8);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", 32'(cap_wstrb), 32'h2);
        bresp_val = 2'b00;

        issue("non_ls", T_BAD, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, 1);
        wait_done("non_ls", 9);

        // SW abandoned by a one-cycle reset while AW is outstanding
        aw_delay = 10; w_delay = 10;
        issue("sw_abort", T_SW, 32'h8, 32'h1111_2222, 0, 32'h0, 0, 0, 0);
        check("sw_abort_awvalid", 32'(axil.awvalid), 32'd1);
        rst_n = 0;
        @(negedge clk);
        check("abort_outputs", {axil.arvalid, axil.awvalid, axil.wvalid, axil.rready,
                                axil.bready, done, mis, err}, 32'd0);
        check("abort_data_reset", data_out, 32'd0);
        rst_n = 1;
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd9);
        aw_delay = 0; w_delay = 0;

        rd_val = 32'h0123_4567;
        issue("lw_recover", T_LW, 32'h8, 32'h0, 1, 32'h0123_4567, 0, 0, 3);
        wait_done("lw_recover", 10);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
